// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, Memory read, valid/ready to decoder, branch redirect
// Optional FETCH_PERF_CNT_EN adds saturating fetch_count / flush_count outputs.
module fetch_unit #(
    parameter int data_length = 32,
    parameter int mem_length  = 32,
    parameter int RESET_PC    = 0,
    localparam int PW         = (mem_length > 1) ? $clog2(mem_length) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic [PW-1:0]          mem_addr,
    output logic                   mem_we,
    output logic [data_length-1:0] mem_wdata,
    input  logic [data_length-1:0] mem_rdata,
    input  logic                   branch_valid,
    input  logic [PW-1:0]          branch_target,
    output logic                   instr_valid,
    output logic [data_length-1:0] instr,
    output logic [PW-1:0]          instr_pc,
    input  logic                   instr_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]            fetch_count,
    output logic [31:0]            flush_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t                 state_q;
    logic [PW-1:0]          pc_q;
    logic [PW-1:0]          pc_d;
    logic [data_length-1:0] instr_q;
    logic [PW-1:0]          instr_pc_q;
    logic                   instr_valid_q;

    // Explicit wrap so non-power-of-2 memories still step modulo mem_length.
    assign pc_d = (pc_q == PW'(mem_length - 1)) ? '0 : pc_q + PW'(1);

    assign mem_addr    = pc_q;
    assign mem_we      = 1'b0;
    assign mem_wdata   = '0;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            pc_q          <= PW'(RESET_PC);
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (branch_valid) begin
                        pc_q <= branch_target;
                    end else if (en) begin
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (branch_valid) begin
                        pc_q <= branch_target;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (branch_valid) begin
                        pc_q    <= branch_target;
                        state_q <= ISSUE;
                    end else begin
                        instr_q       <= mem_rdata;
                        instr_pc_q    <= pc_q;
                        instr_valid_q <= 1'b1;
                        state_q       <= HOLD;
                    end
                end
                HOLD: begin
                    // A redirect drops the held word even if the decoder is accepting it.
                    if (branch_valid) begin
                        pc_q          <= branch_target;
                        instr_valid_q <= 1'b0;
                        state_q       <= ISSUE;
                    end else if (instr_ready) begin
                        pc_q          <= pc_d;
                        instr_valid_q <= 1'b0;
                        state_q       <= en ? ISSUE : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q;
    logic [31:0] flush_count_q;
    logic        accept;
    logic        flush;

    assign accept      = (state_q == HOLD) && instr_ready && !branch_valid;
    assign flush       = (state_q != IDLE) && branch_valid;
    assign fetch_count = fetch_count_q;
    assign flush_count = flush_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            if (accept && (fetch_count_q != '1)) fetch_count_q <= fetch_count_q + 32'd1;
            if (flush && (flush_count_q != '1)) flush_count_q <= flush_count_q + 32'd1;
        end
    end
`endif

endmodule
